// File: rtl/sync_fifo_drain.sv
// sync_fifo_drain: drains a non-showahead FIFO (1-cycle q latency) into a full-rate valid/ready stream
// through a 3-entry skid buffer that absorbs the read latency.
module sync_fifo_drain #(
    parameter int FIFO_DATA_WIDTH = 512,
    parameter int CNT_WIDTH = 32
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [FIFO_DATA_WIDTH-1:0] fifo_q,
    input  logic                       fifo_empty,
    output logic                       fifo_rdreq,
    output logic [FIFO_DATA_WIDTH-1:0] out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [1:0]                 buf_count,
    output logic [CNT_WIDTH-1:0]       xfer_count
);
    logic [FIFO_DATA_WIDTH-1:0] mem [3];
    logic [1:0] wr_ptr, rd_ptr;
    logic inflight, pop;

    // The word already in flight holds a slot, so a stalled consumer can never overflow the buffer.
    assign fifo_rdreq = !reset && !fifo_empty && (({1'b0, buf_count} + {2'b0, inflight}) < 3'd3);
    assign out_valid = buf_count != 2'd0;
    assign out_data = mem[rd_ptr];
    assign pop = out_valid && out_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mem <= '{default: '0};
            wr_ptr <= 2'd0;
            rd_ptr <= 2'd0;
            inflight <= 1'b0;
            buf_count <= 2'd0;
            xfer_count <= '0;
        end else begin
            inflight <= fifo_rdreq;
            if (inflight) begin
                mem[wr_ptr] <= fifo_q;
                wr_ptr <= (wr_ptr == 2'd2) ? 2'd0 : wr_ptr + 2'd1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == 2'd2) ? 2'd0 : rd_ptr + 2'd1;
                xfer_count <= xfer_count + 1'b1;
            end
            buf_count <= buf_count + {1'b0, inflight} - {1'b0, pop};
        end
    end

`ifndef SYNTHESIS
    a_no_overflow: assert property (@(posedge clock) disable iff (reset)
        ({1'b0, buf_count} + {2'b0, inflight}) <= 3'd3);
    a_no_underflow: assert property (@(posedge clock) disable iff (reset)
        !(fifo_rdreq && fifo_empty));
    a_stall_stable: assert property (@(posedge clock) disable iff (reset)
        out_valid && !out_ready |=> $stable(out_data));
`endif
endmodule

// File: tb/tb_sync_fifo_drain.sv
// tb_sync_fifo_drain: randomized scenarios against a queue-based FIFO model and in-order scoreboard.
module tb_sync_fifo_drain;
    localparam int W = 64;
    localparam int CW = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic [W-1:0] fifo_q = '0;
    logic fifo_empty = 1'b1;
    logic fifo_rdreq, out_valid;
    logic out_ready = 1'b0;
    logic [W-1:0] out_data;
    logic [1:0] buf_count;
    logic [CW-1:0] xfer_count;
    int n_checks = 0;
    int n_fail = 0;
    logic [W-1:0] fifo_mem[$];
    logic [W-1:0] exp_q[$];
    bit rd_seen;

    sync_fifo_drain #(.FIFO_DATA_WIDTH(W), .CNT_WIDTH(CW)) dut (
        .clock(clock), .reset(reset), .fifo_q(fifo_q), .fifo_empty(fifo_empty),
        .fifo_rdreq(fifo_rdreq), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .buf_count(buf_count), .xfer_count(xfer_count)
    );

    always #5 clock = ~clock;

    // Behavioural scfifo: q and empty change just after the edge that accepts a read or write.
    always @(posedge clock) begin
        rd_seen = fifo_rdreq;
        #1;
        if (rd_seen && fifo_mem.size() > 0) fifo_q = fifo_mem.pop_front();
        fifo_empty = fifo_mem.size() == 0;
    end

    task automatic push(input logic [W-1:0] d);
        fifo_mem.push_back(d);
        exp_q.push_back(d);
    endtask

    task automatic apply_reset(input int n, input bit seq);
        @(negedge clock);
        reset = 1'b1;
        out_ready = 1'b0;
        fifo_mem.delete();
        exp_q.delete();
        for (int i = 0; i < n; i++) push(seq ? W'(i + 1) : {$urandom, $urandom});
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_reset;
        for (int i = 0; i < 3; i++) push({$urandom, $urandom});
        repeat (2) @(negedge clock);
        #1;
        n_checks += 5;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", out_valid); end
        if (buf_count !== 2'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", buf_count); end
        if (xfer_count !== '0) begin n_fail++; $display("FAIL reset_xfer got %0d want 0", xfer_count); end
        if (out_data !== '0) begin n_fail++; $display("FAIL reset_data got %h want 0", out_data); end
        if (fifo_rdreq !== 1'b0) begin n_fail++; $display("FAIL reset_rdreq got %b want 0", fifo_rdreq); end
    endtask

    task automatic test_fill;
        int got = 0;
        int last = -1;
        logic [W-1:0] e;
        apply_reset(5, 1'b1);
        for (int c = 0; c < 12; c++) begin
            out_ready = 1'b1;
            #1;
            if (c == 0) begin
                n_checks++;
                if (fifo_rdreq !== 1'b1) begin n_fail++; $display("FAIL fill_rdreq0 got %b want 1", fifo_rdreq); end
            end
            if (c < 2) begin
                n_checks++;
                if (out_valid !== 1'b0) begin n_fail++; $display("FAIL fill_early_valid c=%0d got %b want 0", c, out_valid); end
            end
            if (c == 2) begin
                n_checks++;
                if (out_valid !== 1'b1) begin n_fail++; $display("FAIL fill_valid2 got %b want 1", out_valid); end
            end
            if (out_valid && out_ready) begin
                e = exp_q.size() ? exp_q.pop_front() : 'x;
                n_checks++;
                if (out_data !== e) begin n_fail++; $display("FAIL fill_data c=%0d got %h want %h", c, out_data, e); end
                got++;
                last = c;
            end
            @(negedge clock);
        end
        #1;
        n_checks += 4;
        if (got != 5) begin n_fail++; $display("FAIL fill_words got %0d want 5", got); end
        if (last != 6) begin n_fail++; $display("FAIL fill_last_cycle got %0d want 6", last); end
        if (xfer_count !== CW'(5)) begin n_fail++; $display("FAIL fill_xfer got %0d want 5", xfer_count); end
        if (buf_count !== 2'd0) begin n_fail++; $display("FAIL fill_count got %0d want 0", buf_count); end
    endtask

    task automatic test_backpressure;
        int pulses = 0;
        int got = 0;
        int gaps = 0;
        logic [W-1:0] e;
        apply_reset(8, 1'b0);
        for (int c = 0; c < 10; c++) begin
            out_ready = 1'b0;
            #1;
            pulses += int'(fifo_rdreq);
            @(negedge clock);
        end
        #1;
        n_checks += 3;
        if (pulses != 3) begin n_fail++; $display("FAIL bp_rdreq_pulses got %0d want 3", pulses); end
        if (buf_count !== 2'd3) begin n_fail++; $display("FAIL bp_count got %0d want 3", buf_count); end
        if (out_data !== exp_q[0]) begin n_fail++; $display("FAIL bp_head got %h want %h", out_data, exp_q[0]); end
        @(negedge clock);
        for (int c = 0; c < 20; c++) begin
            out_ready = 1'b1;
            #1;
            if (out_valid) begin
                e = exp_q.size() ? exp_q.pop_front() : 'x;
                n_checks++;
                if (out_data !== e) begin n_fail++; $display("FAIL bp_data c=%0d got %h want %h", c, out_data, e); end
                got++;
            end else if (got > 0 && got < 8) gaps++;
            @(negedge clock);
        end
        #1;
        n_checks += 3;
        if (got != 8) begin n_fail++; $display("FAIL bp_words got %0d want 8", got); end
        if (gaps != 0) begin n_fail++; $display("FAIL bp_gaps got %0d want 0", gaps); end
        if (xfer_count !== CW'(8)) begin n_fail++; $display("FAIL bp_xfer got %0d want 8", xfer_count); end
    endtask

    task automatic test_stall;
        int got = 0;
        bit stalled = 1'b0;
        logic [W-1:0] held = '0;
        logic [W-1:0] e;
        logic [CW-1:0] nx = '0;
        apply_reset(20, 1'b0);
        for (int c = 0; c < 60; c++) begin
            out_ready = (c % 2) == 0;
            #1;
            if (stalled) begin
                n_checks++;
                if (out_data !== held) begin n_fail++; $display("FAIL stall_stable c=%0d got %h want %h", c, out_data, held); end
            end
            if (out_valid && out_ready) begin
                e = exp_q.size() ? exp_q.pop_front() : 'x;
                n_checks++;
                if (out_data !== e) begin n_fail++; $display("FAIL stall_data c=%0d got %h want %h", c, out_data, e); end
                got++;
                nx++;
            end
            stalled = out_valid && !out_ready;
            held = out_data;
            @(negedge clock);
        end
        #1;
        n_checks += 2;
        if (got != 20) begin n_fail++; $display("FAIL stall_words got %0d want 20", got); end
        if (xfer_count !== nx) begin n_fail++; $display("FAIL stall_xfer got %0d want %0d", xfer_count, nx); end
    endtask

    task automatic test_single;
        int pulses = 0;
        int vcount = 0;
        int t_fall = -1;
        int t_valid = -1;
        logic [W-1:0] e;
        apply_reset(0, 1'b0);
        out_ready = 1'b1;
        repeat (3) @(negedge clock);
        push({$urandom, $urandom});
        e = exp_q[0];
        for (int c = 0; c < 8; c++) begin
            out_ready = 1'b1;
            #1;
            if (!fifo_empty && t_fall < 0) t_fall = c;
            pulses += int'(fifo_rdreq);
            if (out_valid) begin
                if (t_valid < 0) t_valid = c;
                vcount++;
                n_checks++;
                if (out_data !== e) begin n_fail++; $display("FAIL single_data got %h want %h", out_data, e); end
            end
            @(negedge clock);
        end
        n_checks += 3;
        if (pulses != 1) begin n_fail++; $display("FAIL single_rdreq got %0d want 1", pulses); end
        if (vcount != 1) begin n_fail++; $display("FAIL single_valid_cycles got %0d want 1", vcount); end
        if (t_fall < 0 || t_valid - t_fall != 2) begin
            n_fail++; $display("FAIL single_latency got %0d want 2", t_valid - t_fall);
        end
    endtask

    task automatic test_reset_mid;
        int bad = 0;
        apply_reset(10, 1'b0);
        for (int c = 0; c < 10; c++) begin
            out_ready = 1'b0;
            #1;
            if (buf_count == 2'd2) break;
            @(negedge clock);
        end
        n_checks++;
        if (buf_count !== 2'd2) begin n_fail++; $display("FAIL mid_setup got %0d want 2", buf_count); end
        reset = 1'b1;
        fifo_mem.delete();
        exp_q.delete();
        #1;
        n_checks += 4;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid got %b want 0", out_valid); end
        if (buf_count !== 2'd0) begin n_fail++; $display("FAIL mid_count got %0d want 0", buf_count); end
        if (out_data !== '0) begin n_fail++; $display("FAIL mid_data got %h want 0", out_data); end
        if (fifo_rdreq !== 1'b0) begin n_fail++; $display("FAIL mid_rdreq got %b want 0", fifo_rdreq); end
        repeat (2) @(negedge clock);
        reset = 1'b0;
        for (int c = 0; c < 6; c++) begin
            out_ready = 1'b1;
            #1;
            if (fifo_rdreq !== 1'b0 || out_valid !== 1'b0) bad++;
            @(negedge clock);
        end
        n_checks++;
        if (bad != 0) begin n_fail++; $display("FAIL mid_idle got %0d active cycles want 0", bad); end
    endtask

    task automatic test_wrap;
        int got = 0;
        bit saw15 = 1'b0;
        bit wrapped = 1'b0;
        logic [W-1:0] e;
        apply_reset(19, 1'b0);
        for (int c = 0; c < 30; c++) begin
            out_ready = 1'b1;
            #1;
            if (xfer_count == CW'(15)) saw15 = 1'b1;
            if (saw15 && xfer_count == '0) wrapped = 1'b1;
            if (out_valid && out_ready) begin
                e = exp_q.size() ? exp_q.pop_front() : 'x;
                n_checks++;
                if (out_data !== e) begin n_fail++; $display("FAIL wrap_data c=%0d got %h want %h", c, out_data, e); end
                got++;
            end
            @(negedge clock);
        end
        #1;
        n_checks += 3;
        if (got != 19) begin n_fail++; $display("FAIL wrap_words got %0d want 19", got); end
        if (!wrapped) begin n_fail++; $display("FAIL wrap_rollover got 0 want 1"); end
        if (xfer_count !== CW'(3)) begin n_fail++; $display("FAIL wrap_xfer got %0d want 3", xfer_count); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_backpressure();
        test_stall();
        test_single();
        test_reset_mid();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/sync_fifo_drain.md
Name: sync_fifo_drain

Overview:
- Read-side companion for the non-showahead single-clock FIFO (scfifo, lpm_showahead OFF, 1-cycle q latency).
- Issues rdreq against the FIFO's empty flag and absorbs the one-cycle read latency in a 3-entry skid buffer.
- Presents the data as a valid/ready stream at full throughput.
- Sits between a sync_fifo instance and any ready-gated consumer, e.g. the ROB response path.

Parameters:
- FIFO_DATA_WIDTH, 512, width of fifo_q and out_data.
- CNT_WIDTH, 32, width of the delivered-word counter.

Ports:
- clock  input  1  single clock; all logic rising-edge.
- reset  input  1  asynchronous, active-high reset.
- fifo_q  input  FIFO_DATA_WIDTH  FIFO read data, valid the cycle after fifo_rdreq.
- fifo_empty  input  1  FIFO empty flag.
- fifo_rdreq  output  1  FIFO read request.
- out_data  output  FIFO_DATA_WIDTH  head-of-buffer data.
- out_valid  output  1  out_data valid.
- out_ready  input  1  consumer accepts when out_valid && out_ready.
- buf_count  output  2  skid-buffer occupancy, 0..3.
- xfer_count  output  CNT_WIDTH  words delivered since reset, wraps.

Behaviour:
- Reset (asynchronous, active-high, applies immediately): out_valid=0, buf_count=0, xfer_count=0, inflight=0, rd/wr pointers=0, out_data=0. fifo_rdreq=0 while reset is high.
- inflight: register = fifo_rdreq of the previous cycle.
- Read issue: fifo_rdreq = !reset && !fifo_empty && (buf_count + inflight) < 3.
  - Combinational from fifo_empty and registered state only.
  - No combinational path from out_ready to fifo_rdreq.
- Capture: when inflight=1, write fifo_q into buffer[wr_ptr]; wr_ptr advances mod 3.
- Pop: when out_valid && out_ready, rd_ptr advances mod 3 and xfer_count increments, wrapping at 2^CNT_WIDTH.
- buf_count_next = buf_count + inflight - pop; simultaneous capture and pop leaves the count unchanged.
- out_valid = (buf_count != 0). out_data = buffer[rd_ptr], registered storage only.
  - out_data is held stable while out_valid && !out_ready.
- Latency: fifo_empty falls in cycle t -> rdreq in t -> q captured at end of t+1 -> out_valid=1 in t+2.
- Throughput: 1 word/cycle sustained when out_ready is held high and the FIFO is non-empty.
- Backpressure:
  - Issue rule guarantees buf_count never exceeds 3, so no capture is lost.
  - With out_ready=0, at most 3 words leave the FIFO.
- FIFO empty:
  - No rdreq; the FIFO's underflow_checking is never exercised.
  - A pending inflight word still lands.
- Wrap-around: pointers roll 2->0; ordering is strictly FIFO.
- Reset mid-operation:
  - Buffered and inflight words are discarded.
  - The FIFO's own sclr must be asserted in the same reset window.
  - Otherwise a word read in the cycle reset asserts is lost; this is an integration requirement.
- Assertions (sim only):
  - buf_count <= 3.
  - No fifo_rdreq while fifo_empty.
  - out_data stable under stall.

Test Plan:
1. Reset release, FIFO preloaded with 0x1..0x5, out_ready=1 -> rdreq from cycle 0; out_valid from cycle 2; 0x1..0x5 delivered on consecutive cycles; xfer_count=5; buf_count returns to 0.
2. FIFO holding 8 words, out_ready=0 -> exactly 3 rdreq pulses, buf_count=3, out_data=word0 held. Raise out_ready -> 8 words in order, no gaps after the first.
3. out_ready toggling 1,0,1,0 over 20 words -> ordering preserved, out_data stable on every stalled cycle, xfer_count=20, assertions clean.
4. Single word written into an empty FIFO with out_ready=1 -> exactly one rdreq, out_valid for 1 cycle, 2 cycles after fifo_empty falls.
5. Reset asserted mid-stream with buf_count=2 and inflight=1 (FIFO sclr asserted together) -> outputs zero immediately. After release with an empty FIFO: no rdreq, out_valid stays 0.
6. Stream 2^CNT_WIDTH+3 words with CNT_WIDTH overridden to 4 -> xfer_count wraps 15->0 and ends at 3; data intact.
